// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of an N_IN-input gate and checks dut_y against TRUTH.
// Optional first-failure capture is enabled with `GATE_CHK_FIRST_FAIL_EN.
module gate_truth_checker #(
  parameter int N_IN = 2,
  parameter int SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] TRUTH = 4'b1110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_seen
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_FIN
  } state_e;

  localparam logic [N_IN-1:0] LAST = '1;
  localparam logic [3:0] CNT_END = 4'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN:0]   err_q, err_d;
  logic            pass_q, pass_d;
  logic            miss;

  // Case-inequality so X/Z on the gate output counts as a mismatch
  assign miss = (dut_y !== TRUTH[stim_q]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == CNT_END) state_d = S_CHECK;
      S_CHECK: state_d = (stim_q == LAST) ? S_FIN : S_WAIT;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    stim_d = stim_q;
    err_d  = err_q;
    pass_d = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          stim_d = '0;
          err_d  = '0;
          pass_d = 1'b0;
        end
      end
      S_WAIT: cnt_d = cnt_q + 4'd1;
      S_CHECK: begin
        if (miss) err_d = err_q + 1'b1;
        if (stim_q == LAST) begin
          pass_d = (err_d == '0);
        end else begin
          stim_d = stim_q + 1'b1;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
    stim    = stim_q;
    pass    = pass_q;
    err_cnt = err_q;
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [N_IN-1:0] fv_q, fv_d;
  logic            fs_q, fs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fv_q <= '0;
      fs_q <= 1'b0;
    end else begin
      fv_q <= fv_d;
      fs_q <= fs_d;
    end
  end

  always_comb begin
    fv_d = fv_q;
    fs_d = fs_q;
    if (state_q == S_IDLE && start) begin
      fv_d = '0;
      fs_d = 1'b0;
    end else if (state_q == S_CHECK && miss && !fs_q) begin
      fv_d = stim_q;
      fs_d = 1'b1;
    end
  end

  assign fail_vec  = fv_q;
  assign fail_seen = fs_q;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized scoreboard bench for gate_truth_checker (OR2 default and AND3 instances).
// Gate models sit in the bench; expectations come from a truth-table reference.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  typedef struct {
    int err;
    int pss;
    int fv;
    int fs;
    int last;
    int t;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // Gate model: 0 correct, 1 stuck-at-0, 2 X on vector 2, 3 random flip mask
  function automatic logic gfn(bit is_and, int nv, int m, logic [7:0] flt, int k);
    logic b;
    b = is_and ? (k == nv - 1) : (k != 0);
    case (m)
      0: return b;
      1: return 1'b0;
      2: return (k == 2) ? 1'bx : b;
      default: return b ^ flt[k];
    endcase
  endfunction

  function automatic exp_t model(bit is_and, int nv, int m, logic [7:0] flt);
    exp_t e;
    logic ref_y;
    e = '{err: 0, pss: 0, fv: 0, fs: 0, last: nv - 1, t: 0};
    for (int k = 0; k < nv; k++) begin
      ref_y = is_and ? (k == nv - 1) : (k != 0);
      if (gfn(is_and, nv, m, flt, k) !== ref_y) begin
        if (e.fs == 0) e.fv = k;
        e.fs = 1;
        e.err++;
      end
    end
    e.pss = (e.err == 0);
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // OR2 instance (defaults)
  logic       start1 = 1'b0;
  logic       y1;
  logic [1:0] stim1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  int         mode1 = 0;
  logic [7:0] flt1 = '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [1:0] fv1;
  logic       fs1;
`endif

  always_comb y1 = gfn(1'b0, 4, mode1, flt1, int'(stim1));

  gate_truth_checker u_or (
    .clk(clk),
    .rst_n(rst_n),
    .start(start1),
    .dut_y(y1),
    .stim(stim1),
    .busy(busy1),
    .done(done1),
    .pass(pass1),
    .err_cnt(err1)
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    .fail_vec(fv1),
    .fail_seen(fs1)
`endif
  );

  // AND3 instance
  logic       start2 = 1'b0;
  logic       y2;
  logic [2:0] stim2;
  logic       busy2, done2, pass2;
  logic [3:0] err2;
  int         mode2 = 0;
  logic [7:0] flt2 = '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [2:0] fv2;
  logic       fs2;
`endif

  always_comb y2 = gfn(1'b1, 8, mode2, flt2, int'(stim2));

  gate_truth_checker #(
    .N_IN(3),
    .SETTLE(2),
    .TRUTH(8'b1000_0000)
  ) u_and (
    .clk(clk),
    .rst_n(rst_n),
    .start(start2),
    .dut_y(y2),
    .stim(stim2),
    .busy(busy2),
    .done(done2),
    .pass(pass2),
    .err_cnt(err2)
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    .fail_vec(fv2),
    .fail_seen(fs2)
`endif
  );

  // Monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL or_unexpected_done: got done=1 want none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("or_done_cycle", cyc, e.t);
        chk("or_err_cnt", int'(err1), e.err);
        chk("or_pass", int'(pass1), e.pss);
        chk("or_stim_last", int'(stim1), e.last);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("or_fail_vec", int'(fv1), e.fv);
        chk("or_fail_seen", int'(fs1), e.fs);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL and_unexpected_done: got done=1 want none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("and_done_cycle", cyc, e.t);
        chk("and_err_cnt", int'(err2), e.err);
        chk("and_pass", int'(pass2), e.pss);
        chk("and_stim_last", int'(stim2), e.last);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("and_fail_vec", int'(fv2), e.fv);
        chk("and_fail_seen", int'(fs2), e.fs);
`endif
      end
    end
  end

  task automatic sweep1(input int m, input bit rep);
    exp_t e;
    int n;
    @(negedge clk);
    mode1 = m;
    flt1 = 8'($urandom);
    e = model(1'b0, 4, m, flt1);
    e.t = cyc + 1 + 8;
    q1.push_back(e);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    if (rep) begin
      repeat (2) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
    n = 0;
    while ((busy1 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL or_timeout: got busy after %0d cycles want idle", n);
      q1.delete();
    end
    @(negedge clk);
    chk("or_pass_hold", int'(pass1), e.pss);
    chk("or_err_hold", int'(err1), e.err);
  endtask

  task automatic sweep2(input int m);
    exp_t e;
    int n;
    @(negedge clk);
    mode2 = m;
    flt2 = 8'($urandom);
    e = model(1'b1, 8, m, flt2);
    e.t = cyc + 1 + 24;
    q2.push_back(e);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while ((busy2 || q2.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      total++;
      bad++;
      $display("FAIL and_timeout: got busy after %0d cycles want idle", n);
      q2.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_stim", int'(stim1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_err", int'(err1), 0);
    chk("rst_and_busy", int'(busy2), 0);
    rst_n = 1'b1;

    sweep1(0, 1'b0);
    sweep1(1, 1'b0);
    sweep1(2, 1'b0);
    sweep1(3, 1'b1);
    sweep1(0, 1'b1);

    // Abort mid-sweep: reset lands on edge 5, no done expected
    @(negedge clk);
    mode1 = 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_stim", int'(stim1), 0);
    chk("abort_busy", int'(busy1), 0);
    chk("abort_err", int'(err1), 0);
    chk("abort_pass", int'(pass1), 0);
    chk("abort_done", int'(done1), 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    sweep1(0, 1'b0);
    for (int i = 0; i < 6; i++) sweep1($urandom_range(0, 3), 1'(i & 1));

    sweep2(0);
    for (int i = 0; i < 3; i++) sweep2($urandom_range(1, 3));

    repeat (3) @(negedge clk);
    chk("or_queue_empty", q1.size(), 0);
    chk("and_queue_empty", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking sequential stimulus/response block for the gate-level modeling library. It drives every input combination of an N-input combinational gate (user-defined primitive or built-in) and samples the gate output after a programmable settle time. Each sample is compared against a parameterised truth table, and the block reports a mismatch count and a pass flag. It sits on the opposite side of the gate interface from the device under test: the gate receives inputs and drives `y`, while this block drives those inputs and consumes `y`.

## Interface
Parameters:
- `N_IN`, 2: gate input count; legal range 1..6.
- `SETTLE`, 1: cycles each vector is held before its check cycle; legal range 1..15.
- `TRUTH`, 4'b1110: expected output table of width 2^N_IN; bit k is the expected output for stim == k. The default is OR.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: begin a sweep; sampled only in IDLE.
- `dut_y`  in  1: output of the gate under check.
- `stim`  out  N_IN: drive for the gate inputs; bit 0 is the first gate input.
- `busy`  out  1: high from the edge after `start` until the return to IDLE.
- `done`  out  1: one-cycle pulse at the end of a sweep.
- `pass`  out  1: high when the last completed sweep had zero mismatches; holds until the next `start`.
- `err_cnt`  out  N_IN+1: mismatches in the current or last sweep.
- `fail_vec`  out  N_IN: first failing vector. Present only with `FIRST_FAIL_EN`.
- `fail_seen`  out  1: `fail_vec` is valid. Present only with `FIRST_FAIL_EN`.

## Operation
- States: IDLE, WAIT, CHECK, FIN.
- **IDLE**
  - `busy` = 0.
  - When `start` = 1: `stim` <= 0, settle counter <= 0, `err_cnt` <= 0, `pass` <= 0, go to WAIT.
- **WAIT**
  - Settle counter increments each cycle.
  - Go to CHECK when the counter reaches SETTLE-1.
- **CHECK** (one cycle)
  - Sample `dut_y` and compare it with TRUTH[stim].
  - Any mismatch increments `err_cnt`. X or Z on `dut_y` counts as a mismatch (case-inequality).
  - If stim == 2^N_IN-1: go to FIN.
  - Otherwise: stim <= stim+1, counter <= 0, go to WAIT.
- **FIN** (one cycle)
  - `done` = 1.
  - `pass` is registered at the edge entering FIN as (final `err_cnt` == 0).
  - `stim` holds its last value.
  - Go to IDLE.
- Arithmetic rules:
  - `err_cnt` cannot exceed 2^N_IN, so it never saturates or wraps.
  - `stim` never wraps; the sweep ends at all-ones.
- Boundary conditions:
  - `start` while in WAIT, CHECK or FIN is ignored; no restart and no state change.
  - `start` held high continuously starts a new sweep on the first IDLE cycle.
  - Reset mid-sweep aborts the sweep immediately: next state IDLE, no `done` pulse.
- Reset values (with `rst_n` = 0 at an edge):
  - State: IDLE.
  - Outputs: `stim` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0.
  - Macro outputs: `fail_vec` = 0, `fail_seen` = 0.

## Timing
- Edge 0: `start` sampled; `stim` = 0 valid after this edge.
- Vector k (0-based):
  - Driven after edge k·(SETTLE+1).
  - Sampled at edge (k+1)·(SETTLE+1).
  - Stable for SETTLE+1 cycles before sampling.
- `done` and `pass` become valid after edge 2^N_IN·(SETTLE+1).
- `done` drops one edge later; `busy` drops on that same edge.
- `err_cnt` updates on the edge of each failing CHECK.
- Defaults (N_IN=2, SETTLE=1): 8 cycles from the start edge to `done`.

## Configuration
- Macro: `GATE_CHK_FIRST_FAIL_EN`.
- Defined:
  - The `fail_vec` and `fail_seen` ports and registers exist.
  - On the first mismatching CHECK of a sweep: `fail_vec` <= stim, `fail_seen` <= 1.
  - Later mismatches do not overwrite them.
  - Both are cleared to 0 on an accepted `start`.
- Undefined: the ports and registers are absent, and all other behaviour is identical.

## Test plan
- Correct OR gate, defaults: pulse `start` → `stim` steps 0,1,2,3; `done` at cycle 8; `pass` = 1; `err_cnt` = 0.
- Stuck-at-0 gate model: → `err_cnt` = 3, `pass` = 0. With the macro: `fail_vec` = 1, `fail_seen` = 1.
- `dut_y` driven X for vector 2 only, otherwise a correct OR: → `err_cnt` = 1, `pass` = 0.
- `start` re-pulsed at cycles 3 and 7 of a sweep: → ignored; single `done` at cycle 8; the next `start` accepted in IDLE restarts with `err_cnt` = 0.
- `rst_n` = 0 at cycle 5 mid-sweep: → all outputs 0 next cycle; no `done`; a fresh `start` completes normally.
- N_IN=3, SETTLE=2, TRUTH=8'b1000_0000 (AND3) with a correct AND3: → `done` at cycle 24, `pass` = 1, `err_cnt` = 0.
